// File: rtl/usb_uart_tx_arbiter.sv
// Round-robin, message-aware arbiter sharing the usb_uart byte input between two sources.
// Grants are held until EOL, a byte limit, or an idle timeout; output stage is registered.
//
// state    | meaning
// ST_IDLE  | no owner; arbitrate between a_valid and b_valid
// ST_OWN_A | requester A owns the pipeline until release
// ST_OWN_B | requester B owns the pipeline until release
module usb_uart_tx_arbiter #(
  parameter int         BURST_MAX    = 16,
  parameter logic [7:0] EOL_BYTE     = 8'h0A,
  parameter int         IDLE_TIMEOUT = 64
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN_A, ST_OWN_B} state_t;

  localparam logic [7:0]  BURST_LAST = 8'(BURST_MAX - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(IDLE_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        last_served_b;
  logic [7:0]  burst_cnt;
  logic [15:0] idle_tmr;
  logic        own_valid;
  logic [7:0]  own_data;
  logic        stage_free;
  logic        accept;
  logic        release_msg;
  logic        timeout;
  logic        out_valid_nxt;

  always_comb begin
    own_valid = 1'b0;
    own_data  = 8'h00;
    case (state)
      ST_OWN_A: begin
        own_valid = a_valid;
        own_data  = a_data;
      end
      ST_OWN_B: begin
        own_valid = b_valid;
        own_data  = b_data;
      end
      default: ;
    endcase
  end

  assign stage_free  = !out_valid || out_ready;
  assign a_ready     = (state == ST_OWN_A) && stage_free;
  assign b_ready     = (state == ST_OWN_B) && stage_free;
  assign accept      = own_valid && stage_free;
  assign release_msg = accept && ((own_data == EOL_BYTE) || (burst_cnt == BURST_LAST));
  // idle_tmr counts down from IDLE_TIMEOUT-1 while the owner is silent
  assign timeout     = (state != ST_IDLE) && !own_valid && (idle_tmr == 16'd0);
  assign out_valid_nxt = accept || (out_valid && !out_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (a_valid && (!b_valid || last_served_b)) state_nxt = ST_OWN_A;
        else if (b_valid)                           state_nxt = ST_OWN_B;
      end
      default: begin
        if (release_msg || timeout) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      last_served_b <= 1'b1;
      burst_cnt     <= 8'd0;
      idle_tmr      <= 16'd0;
      out_valid     <= 1'b0;
      out_data      <= 8'h00;
      grant         <= 2'b00;
      busy          <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= out_valid_nxt;
      grant     <= {state_nxt == ST_OWN_B, state_nxt == ST_OWN_A};
      busy      <= (state_nxt != ST_IDLE) || out_valid_nxt;
      if (accept) out_data <= own_data;
      if (state == ST_IDLE) begin
        burst_cnt <= 8'd0;
        idle_tmr  <= IDLE_LAST;
        if (state_nxt != ST_IDLE) last_served_b <= (state_nxt == ST_OWN_B);
      end else begin
        if (accept) burst_cnt <= burst_cnt + 8'd1;
        if (own_valid)              idle_tmr <= IDLE_LAST;
        else if (idle_tmr != 16'd0) idle_tmr <= idle_tmr - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// Bench for usb_uart_tx_arbiter: per-cycle vector table plus directed
// burst, backpressure, timeout and async-reset sequences.
module tb_usb_uart_tx_arbiter;

  logic       clk_48mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [7:0] a_data    = 8'h00;
  logic       a_valid   = 1'b0;
  logic       a_ready;
  logic [7:0] b_data    = 8'h00;
  logic       b_valid   = 1'b0;
  logic       b_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] grant;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_48mhz = ~clk_48mhz;

  usb_uart_tx_arbiter #(.BURST_MAX(4), .EOL_BYTE(8'h0A), .IDLE_TIMEOUT(8)) dut (
    .clk_48mhz(clk_48mhz), .reset_n(reset_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct packed {
    logic       rst_n;
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic [1:0] g;
    logic       ar;
    logic       br;
    logic       ov;
    logic [7:0] od;
    logic       bsy;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst_n, input logic av, input logic [7:0] ad,
                              input logic bv, input logic [7:0] bd, input logic ordy,
                              input logic [1:0] g, input logic ar, input logic br,
                              input logic ov, input logic [7:0] od, input logic bsy);
    vec_t v;
    v.rst_n = rst_n; v.av = av; v.ad = ad; v.bv = bv; v.bd = bd; v.ordy = ordy;
    v.g = g; v.ar = ar; v.br = br; v.ov = ov; v.od = od; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(posedge clk_48mhz); #1;
    reset_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;
    @(posedge clk_48mhz); #1;
    reset_n = 1'b1;
  endtask

  logic [7:0] got [$];
  logic [7:0] exp_burst [12];
  logic [1:0] exp_grant [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // single message "HI\n"
    vecs[0]  = mk(0,0,8'h00,0,8'h00,1, 2'd0,0,0,0,8'h00,0);
    vecs[1]  = mk(1,0,8'h00,0,8'h00,1, 2'd0,0,0,0,8'h00,0);
    vecs[2]  = mk(1,1,8'h48,0,8'h00,1, 2'd0,0,0,0,8'h00,0);
    vecs[3]  = mk(1,1,8'h48,0,8'h00,1, 2'd1,1,0,0,8'h00,1);
    vecs[4]  = mk(1,1,8'h49,0,8'h00,1, 2'd1,1,0,1,8'h48,1);
    vecs[5]  = mk(1,1,8'h0A,0,8'h00,1, 2'd1,1,0,1,8'h49,1);
    vecs[6]  = mk(1,0,8'h00,0,8'h00,1, 2'd0,0,0,1,8'h0A,1);
    // contention from reset, then a second tie
    vecs[7]  = mk(0,0,8'h00,0,8'h00,1, 2'd0,0,0,0,8'h00,0);
    vecs[8]  = mk(1,1,8'h78,1,8'h78,1, 2'd0,0,0,0,8'h00,0);
    vecs[9]  = mk(1,1,8'h78,1,8'h78,1, 2'd1,1,0,0,8'h00,1);
    vecs[10] = mk(1,1,8'h0A,1,8'h78,1, 2'd1,1,0,1,8'h78,1);
    vecs[11] = mk(1,0,8'h00,1,8'h78,1, 2'd0,0,0,1,8'h0A,1);
    vecs[12] = mk(1,0,8'h00,1,8'h78,1, 2'd2,0,1,0,8'h0A,1);
    vecs[13] = mk(1,0,8'h00,1,8'h0A,1, 2'd2,0,1,1,8'h78,1);
    vecs[14] = mk(1,1,8'h41,1,8'h42,1, 2'd0,0,0,1,8'h0A,1);
    vecs[15] = mk(1,1,8'h41,1,8'h42,1, 2'd1,1,0,0,8'h0A,1);
    vecs[16] = mk(1,1,8'h0A,1,8'h42,1, 2'd1,1,0,1,8'h41,1);
    vecs[17] = mk(1,0,8'h00,1,8'h42,1, 2'd0,0,0,1,8'h0A,1);
    vecs[18] = mk(1,0,8'h00,1,8'h42,1, 2'd2,0,1,0,8'h0A,1);
    vecs[19] = mk(1,0,8'h00,1,8'h0A,1, 2'd2,0,1,1,8'h42,1);
    vecs[20] = mk(1,0,8'h00,0,8'h00,1, 2'd0,0,0,1,8'h0A,1);
    vecs[21] = mk(1,0,8'h00,0,8'h00,1, 2'd0,0,0,0,8'h0A,0);

    exp_burst = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h7A, 8'h0A, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    exp_grant = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2,
                  2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1};

    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk_48mhz); #1;
      reset_n = vecs[i].rst_n; a_valid = vecs[i].av; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_data = vecs[i].bd; out_ready = vecs[i].ordy;
      @(negedge clk_48mhz);
      chk($sformatf("vec%0d {grant,a_rdy,b_rdy,ov,od,busy}", i),
          32'({grant, a_ready, b_ready, out_valid, out_data, busy}),
          32'({vecs[i].g, vecs[i].ar, vecs[i].br, vecs[i].ov, vecs[i].od, vecs[i].bsy}));
    end

    // burst limit of 4: A streams 10 bytes, B waits with "z\n"
    begin
      int ai, bi;
      logic acc_a, acc_b;
      ai = 0; bi = 0; acc_a = 1'b0; acc_b = 1'b0;
      got.delete();
      do_reset();
      for (int k = 0; k < 18; k++) begin
        if (k > 0) begin
          @(posedge clk_48mhz); #1;
        end
        if (acc_a) ai++;
        if (acc_b) bi++;
        a_valid = (ai < 10);
        a_data  = 8'(ai + 1);
        b_valid = (bi < 2);
        b_data  = (bi == 0) ? 8'h7A : 8'h0A;
        @(negedge clk_48mhz);
        if (k < 16) chk($sformatf("burst grant k%0d", k), 32'(grant), 32'(exp_grant[k]));
        if (out_valid && out_ready) got.push_back(out_data);
        acc_a = a_valid && a_ready;
        acc_b = b_valid && b_ready;
      end
      chk("burst byte count", 32'(got.size()), 32'd12);
      for (int i = 0; i < 12 && i < got.size(); i++)
        chk($sformatf("burst byte %0d", i), 32'(got[i]), 32'(exp_burst[i]));
    end

    // backpressure: first byte held for 5 stalled cycles
    begin
      logic [7:0] bp_bytes [3];
      int ai;
      logic acc_a;
      bp_bytes = '{8'h11, 8'h22, 8'h33};
      got.delete();
      do_reset();
      a_valid = 1'b1; a_data = bp_bytes[0];
      @(posedge clk_48mhz); #1;
      @(negedge clk_48mhz);
      chk("bp grant", 32'(grant), 32'd1);
      @(posedge clk_48mhz); #1;
      a_data = bp_bytes[1]; out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
        @(negedge clk_48mhz);
        chk($sformatf("bp stall%0d out_valid", s), 32'(out_valid), 32'd1);
        chk($sformatf("bp stall%0d out_data", s), 32'(out_data), 32'h11);
        chk($sformatf("bp stall%0d a_ready", s), 32'(a_ready), 32'd0);
        @(posedge clk_48mhz); #1;
      end
      out_ready = 1'b1;
      ai = 1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_48mhz);
        if (out_valid && out_ready) got.push_back(out_data);
        acc_a = a_valid && a_ready;
        @(posedge clk_48mhz); #1;
        if (acc_a) ai++;
        a_valid = (ai < 3);
        a_data  = (ai < 3) ? bp_bytes[ai] : 8'h00;
      end
      chk("bp byte count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3 && i < got.size(); i++)
        chk($sformatf("bp byte %0d", i), 32'(got[i]), 32'(bp_bytes[i]));
    end

    // idle timeout of 8 cycles after the owner drops valid
    do_reset();
    a_valid = 1'b1; a_data = 8'h55;
    @(posedge clk_48mhz); #1;
    @(negedge clk_48mhz);
    chk("to grant before accept", 32'(grant), 32'd1);
    @(posedge clk_48mhz); #1;
    a_valid = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      if (j > 0) begin
        @(posedge clk_48mhz); #1;
      end
      @(negedge clk_48mhz);
      chk($sformatf("to grant T+%0d", j), 32'(grant), (j < 8) ? 32'd1 : 32'd0);
    end

    // async reset mid-message while a byte sits in the output stage
    do_reset();
    a_valid = 1'b1; a_data = 8'h66; out_ready = 1'b0;
    @(posedge clk_48mhz); #1;
    @(posedge clk_48mhz); #1;
    @(negedge clk_48mhz);
    chk("ar pre {grant,ov,od,busy}", 32'({grant, out_valid, out_data, busy}), 32'({2'd1, 1'b1, 8'h66, 1'b1}));
    #1 out_ready = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("ar async {grant,a_rdy,b_rdy,ov,od,busy}",
        32'({grant, a_ready, b_ready, out_valid, out_data, busy}), 32'd0);
    @(posedge clk_48mhz); #1;
    reset_n = 1'b1; a_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
